// File: rtl/scr1_dmem_copier.sv
// Block-copy engine acting as a second dmem initiator: one word is read and
// then written back at the destination, with a single transaction in flight.
module scr1_dmem_copier #(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AWIDTH-1:0]    src_addr,
    input  logic [AWIDTH-1:0]    dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [LEN_WIDTH-1:0] words_done,
    output logic                 dmem_req,
    output logic                 dmem_cmd,
    output logic [1:0]           dmem_width,
    output logic [AWIDTH-1:0]    dmem_addr,
    output logic [DWIDTH-1:0]    dmem_wdata,
    input  logic                 dmem_req_ack,
    input  logic [DWIDTH-1:0]    dmem_rdata,
    input  logic [1:0]           dmem_resp
);

    localparam logic       CMD_RD     = 1'b0;
    localparam logic       CMD_WR     = 1'b1;
    localparam logic [1:0] RESP_OK    = 2'b01;
    localparam logic [1:0] RESP_ER    = 2'b10;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RSP,
        ST_WR_REQ,
        ST_WR_RSP
    } state_t;

    state_t                 state_reg;
    logic [AWIDTH-1:0]      src_reg;
    logic [AWIDTH-1:0]      dst_reg;
    logic [LEN_WIDTH-1:0]   remain_reg;
    logic [AWIDTH-1:0]      src_inc;
    logic [AWIDTH-1:0]      dst_inc;
    logic                   cmd_misaligned;

    // Address arithmetic wraps naturally modulo 2^AWIDTH.
    assign src_inc        = src_reg + AWIDTH'(4);
    assign dst_inc        = dst_reg + AWIDTH'(4);
    assign cmd_misaligned = (|src_addr[1:0]) | (|dst_addr[1:0]);

    assign busy       = (state_reg != ST_IDLE);
    assign dmem_width = WIDTH_WORD;

    // dmem_wdata doubles as the read-data buffer between the read and the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            src_reg    <= '0;
            dst_reg    <= '0;
            remain_reg <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            words_done <= '0;
            dmem_req   <= 1'b0;
            dmem_cmd   <= CMD_RD;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        src_reg    <= src_addr;
                        dst_reg    <= dst_addr;
                        remain_reg <= len;
                        err        <= 1'b0;
                        words_done <= '0;
                        if (cmd_misaligned) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state_reg <= ST_RD_REQ;
                            dmem_req  <= 1'b1;
                            dmem_cmd  <= CMD_RD;
                            dmem_addr <= src_addr;
                        end
                    end
                end

                ST_RD_REQ: begin
                    if (dmem_req_ack) begin
                        dmem_req  <= 1'b0;
                        state_reg <= ST_RD_RSP;
                    end
                end

                ST_RD_RSP: begin
                    if (dmem_resp == RESP_OK) begin
                        dmem_wdata <= dmem_rdata;
                        dmem_req   <= 1'b1;
                        dmem_cmd   <= CMD_WR;
                        dmem_addr  <= dst_reg;
                        state_reg  <= ST_WR_REQ;
                    end else if (dmem_resp == RESP_ER) begin
                        err       <= 1'b1;
                        done      <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end

                ST_WR_REQ: begin
                    if (dmem_req_ack) begin
                        dmem_req  <= 1'b0;
                        state_reg <= ST_WR_RSP;
                    end
                end

                ST_WR_RSP: begin
                    if (dmem_resp == RESP_OK) begin
                        words_done <= words_done + LEN_WIDTH'(1);
                        src_reg    <= src_inc;
                        dst_reg    <= dst_inc;
                        remain_reg <= remain_reg - LEN_WIDTH'(1);
                        if (remain_reg == LEN_WIDTH'(1)) begin
                            done      <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            dmem_req  <= 1'b1;
                            dmem_cmd  <= CMD_RD;
                            dmem_addr <= src_inc;
                            state_reg <= ST_RD_REQ;
                        end
                    end else if (dmem_resp == RESP_ER) begin
                        err       <= 1'b1;
                        done      <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    dmem_req  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_dmem_copier.sv
// Randomised scoreboard bench for scr1_dmem_copier with a dmem responder that
// injects ack/response delays, garbage responses outside RSP states and errors.
module tb_scr1_dmem_copier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, err;
    logic [15:0] words_done;
    logic        dmem_req, dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_req_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [1:0]  dmem_resp = 2'b00;

    scr1_dmem_copier #(.AWIDTH(32), .DWIDTH(32), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .err(err), .words_done(words_done),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } txn_t;
    typedef struct { bit err; int wd; } done_t;

    txn_t  exp_q[$];
    done_t done_q[$];
    logic [31:0] mem_ovr [logic [31:0]];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int first_req_cyc = -1;
    int done_cyc = -1;

    // responder knobs and state
    int ack_lo = 0, ack_hi = 0, rsp_lo = 0, rsp_hi = 0;
    int err_rd = -1, err_wr = -1;
    int rd_cnt = 0, wr_cnt = 0;
    bit armed = 0, pending = 0, pend_err = 0, pend_wr = 0;
    int ack_wait = 0, resp_wait = 0;
    logic [31:0] pend_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Responder: drives inputs just after the rising edge.
    initial forever begin
        @(posedge clk); #1;
        dmem_req_ack = 1'b0;
        dmem_rdata   = $urandom;
        dmem_resp    = 2'($urandom_range(2, 0));
        if (!rst_n) begin
            armed = 0; pending = 0; dmem_resp = 2'b00;
        end else if (pending) begin
            dmem_resp = 2'b00;
            if (resp_wait == 0) begin
                pending = 0;
                if (pend_err) dmem_resp = 2'b10;
                else begin
                    dmem_resp = 2'b01;
                    if (!pend_wr) dmem_rdata = data_of(pend_addr);
                end
            end else resp_wait--;
        end else if (dmem_req) begin
            if (!armed) begin
                armed = 1;
                ack_wait = $urandom_range(ack_hi, ack_lo);
            end
            if (ack_wait == 0) begin
                dmem_req_ack = 1'b1;
                armed = 0; pending = 1;
                resp_wait = $urandom_range(rsp_hi, rsp_lo);
                pend_wr = dmem_cmd; pend_addr = dmem_addr;
                if (dmem_cmd) begin pend_err = (wr_cnt == err_wr); wr_cnt++; end
                else          begin pend_err = (rd_cnt == err_rd); rd_cnt++; end
            end else ack_wait--;
        end
    end

    // Monitor: samples on the falling edge, pops and compares.
    bit h_valid = 0;
    logic h_cmd = 0;
    logic [31:0] h_addr = '0, h_wdata = '0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) h_valid = 0;
        else begin
            if (h_valid) begin
                chk("hold_req", dmem_req, 1);
                chk("hold_addr", dmem_addr, h_addr);
                chk("hold_cmd", dmem_cmd, h_cmd);
                chk("hold_wdata", dmem_wdata, h_wdata);
            end
            if (dmem_req && first_req_cyc < 0) first_req_cyc = cyc;
            if (dmem_req && dmem_req_ack) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_req: got cmd=%0d addr=%h required no request", dmem_cmd, dmem_addr);
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    chk("txn_cmd", dmem_cmd, t.wr);
                    chk("txn_addr", dmem_addr, t.addr);
                    chk("txn_width", dmem_width, 2'b10);
                    if (t.wr) chk("txn_wdata", dmem_wdata, t.data);
                    $display("txn %s addr=%h wdata=%h", dmem_cmd ? "WR" : "RD", dmem_addr, dmem_wdata);
                end
            end
            h_valid = dmem_req && !dmem_req_ack;
            h_cmd = dmem_cmd; h_addr = dmem_addr; h_wdata = dmem_wdata;
            if (done) begin
                done_cyc = cyc;
                if (done_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL spurious_done: got done=1 required 0");
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_err", err, d.err);
                    chk("done_words", words_done, d.wd);
                    chk("done_busy", busy, 0);
                    $display("done err=%0d words_done=%0d", err, words_done);
                end
            end
        end
    end

    // Reference model: the command as a list of bus transactions plus its outcome.
    task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n,
                         input int erd, input int ewr, input int al, input int ah,
                         input int rl, input int rh);
        done_t dn;
        bit stopped = 0;
        dn.err = 0; dn.wd = n;
        if (s[1:0] != 2'b00 || d[1:0] != 2'b00) begin
            dn.err = 1; dn.wd = 0;
        end else begin
            for (int i = 0; i < n && !stopped; i++) begin
                logic [31:0] sa, da;
                sa = s + 32'(4 * i);
                da = d + 32'(4 * i);
                exp_q.push_back('{0, sa, 32'h0});
                if (i == erd) begin dn.err = 1; dn.wd = i; stopped = 1; end
                else begin
                    exp_q.push_back('{1, da, data_of(sa)});
                    if (i == ewr) begin dn.err = 1; dn.wd = i; stopped = 1; end
                end
            end
        end
        done_q.push_back(dn);
        err_rd = erd; err_wr = ewr; rd_cnt = 0; wr_cnt = 0;
        ack_lo = al; ack_hi = ah; rsp_lo = rl; rsp_hi = rh;
        src_addr = s; dst_addr = d; len = 16'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns in the cycle done is high; optionally pokes a stray start while busy.
    task automatic wait_done(input int poke);
        for (int k = 0; k < 4000; k++) begin
            if (done) begin start = 1'b0; return; end
            start = (poke > 0 && k == poke && busy);
            if (start) begin
                src_addr = $urandom & 32'hFFFF_FFFC;
                dst_addr = $urandom & 32'hFFFF_FFFC;
                len = 16'($urandom_range(9, 1));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_cmp++; n_fail++;
        $display("FAIL done_timeout: got no done within 4000 cycles required done");
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] d, input int n,
                       input int erd, input int ewr, input int al, input int ah,
                       input int rl, input int rh, input int poke);
        issue(s, d, n, erd, ewr, al, ah, rl, rh);
        wait_done(poke);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_words", words_done, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_cmd", dmem_cmd, 0);
        chk("rst_width", dmem_width, 2'b10);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        // basic copy with immediate ack and 1-cycle response
        mem_ovr[32'h100] = 32'hA; mem_ovr[32'h104] = 32'hB; mem_ovr[32'h108] = 32'hC;
        first_req_cyc = -1;
        run(32'h100, 32'h200, 3, -1, -1, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("basic_latency", done_cyc - first_req_cyc, 12);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);

        // backpressure: ack after 5 cycles, response 3 cycles after ack
        run(32'h100, 32'h200, 3, -1, -1, 5, 5, 2, 2, 0);
        // read error on the second read
        run(32'h300, 32'h400, 4, 1, -1, 0, 2, 0, 2, 0);
        chk("rd_err_busy", busy, 0);
        // edge commands
        first_req_cyc = -1;
        run(32'h500, 32'h600, 0, -1, -1, 0, 0, 0, 0, 0);
        run(32'h102, 32'h200, 3, -1, -1, 0, 0, 0, 0, 0);
        run(32'h100, 32'h203, 3, -1, -1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("edge_no_req", first_req_cyc, -1);
        // address wrap with a stray start mid-copy
        run(32'hFFFF_FFFC, 32'h800, 2, -1, -1, 0, 3, 0, 3, 3);
        // write error on the third word
        run(32'h900, 32'hA00, 3, -1, 2, 0, 2, 0, 2, 0);

        // randomized commands, issued back to back in the done cycle
        for (int r = 0; r < 40; r++) begin
            logic [31:0] s, d;
            int n, erd, ewr;
            s = $urandom & 32'hFFFF_FFFC;
            d = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(7, 0) == 0) s = s | 32'($urandom_range(3, 1));
            if ($urandom_range(7, 0) == 0) d = d | 32'($urandom_range(3, 1));
            n = $urandom_range(6, 0);
            erd = ($urandom_range(5, 0) == 0) ? $urandom_range(5, 0) : -1;
            ewr = ($urandom_range(5, 0) == 0) ? $urandom_range(5, 0) : -1;
            run(s, d, n, erd, ewr, 0, $urandom_range(3, 0), 0, $urandom_range(3, 0),
                ($urandom_range(1, 0) == 1) ? $urandom_range(10, 1) : 0);
        end

        // reset while in WR_REQ aborts without a done pulse
        issue(32'h1000, 32'h2000, 4, -1, -1, 2, 2, 0, 1);
        begin
            bit seen = 0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge clk);
                if (dmem_req && dmem_cmd) seen = 1;
            end
            chk("reach_wr_req", seen, 1);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("abort_req", dmem_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        done_q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (5) begin @(posedge clk); #1; end
        run(32'h3000, 32'h4000, 3, -1, -1, 0, 1, 0, 1, 0);

        repeat (4) begin @(posedge clk); #1; end
        chk("leftover_txns", exp_q.size(), 0);
        chk("leftover_dones", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
